scalar_regfile_wb: RTL
======================

# scalar_regfile_wb

Writeback-side consumer of the EX/WB pipeline register: the 16-entry scalar register file with write-through bypass, a second write source for long-latency (load) results behind a valid/ready handshake, and a pending-write scoreboard. The scoreboard drives `hazard_stall` back to the upstream pipeline registers. It sits at the end of the scalar pipe. It takes `wb_*` from the EX/WB register, load returns from the memory interface, and read addresses from decode.

## Interface
- `DATA_WIDTH`, from `qtpa_pkg`, register data width
- `NUM_REGS`, 16, from `qtpa_pkg`, register count; address width `REG_ADDR_W` = 4
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: reset, asynchronous, active-low
- `wb_we` in 1: ALU writeback enable, from the EX/WB register
- `wb_rd_addr` in 4: ALU writeback destination
- `wb_alu_result` in DATA_WIDTH: ALU writeback data
- `ld_valid` in 1: load return valid
- `ld_ready` out 1: load return accepted this cycle
- `ld_rd_addr` in 4: load destination
- `ld_data` in DATA_WIDTH: load data
- `iss_valid` in 1: instruction leaving decode this cycle
- `iss_long` in 1: that instruction writes its rd via the load port
- `iss_rd_addr` in 4: its destination
- `flush` in 1: kills the instruction issuing this cycle
- `rs1_addr`, `rs2_addr` in 4: read addresses
- `rs1_data`, `rs2_data` out DATA_WIDTH: read data
- `hazard_stall` out 1: stall request to the upstream pipeline registers

## Operation
- r0 always reads 0. Writes to r0 from either port are discarded, and r0 is never marked busy.
- Write arbitration: the ALU port has priority.
  - `ld_ready = ~wb_we`.
  - A load is accepted when `ld_valid & ld_ready`.
  - Both sources never write in the same cycle.
  - `ld_valid` is held by the source until accepted. `ld_rd_addr` and `ld_data` stay stable while `ld_valid` is high and not accepted.
- Reads are combinational, with bypass priority (highest first):
  1. r0 → 0
  2. ALU write in this cycle to the same address → `wb_alu_result`
  3. Accepted load in this cycle to the same address → `ld_data`
  4. Array contents
- Scoreboard (`busy[15:0]`):
  - Set `busy[iss_rd_addr]` when `iss_valid & iss_long & ~flush & ~hazard_stall & iss_rd_addr != 0`.
  - Clear `busy[ld_rd_addr]` on load accept.
  - If set and clear hit the same index in one cycle, set wins.
- `hazard_stall` is asserted when any of these holds:
  - RAW on rs1: `busy[rs1_addr]`, and it is not cleared by a load accepted this cycle to that address.
  - RAW on rs2: the same rule for `rs2_addr`.
  - WAW: `iss_valid & busy[iss_rd_addr]`.
- Load accepted to a non-busy rd: the data is written normally and the scoreboard is unchanged.
- `flush` does not clear `busy`. Loads already issued still return and write.

## Timing
- Array writes and scoreboard updates take effect on posedge. A write in cycle N is visible through bypass in cycle N and from the array in cycle N+1.
- `rs*_data`, `ld_ready` and `hazard_stall` are combinational. There is no added latency.
- On reset assertion, immediately and asynchronously:
  - All 16 registers become 0 and all `busy` bits become 0.
  - Consequently `rs1_data`/`rs2_data` read 0 unless bypassed, and `hazard_stall` is 0.
  - `ld_ready` is forced to 0 while reset is asserted.
- Reset asserted mid-operation:
  - Pending busy bits are lost.
  - Load returns arriving during reset are not accepted.
  - A load return arriving after reset to a non-busy rd is written as above.

## Structure
- `qtpa_pkg` holds `DATA_WIDTH`, `NUM_REGS`, `REG_ADDR_W`, and a typedef `reg_addr_t` (logic [REG_ADDR_W-1:0]).
- Sub-module `reg_scoreboard` holds the busy vector, the set/clear logic and hazard evaluation. The register array, arbitration and bypass live in the top module.

## Test plan
- Reset, then read r1..r15 → 0. Write r0=0xDEAD via ALU, read r0 → 0, and the array is unchanged.
- ALU write r3=0x1234 with `rs1_addr`=3 in the same cycle → `rs1_data`=0x1234 that cycle, and it persists in the next cycle after `wb_we` drops.
- Issue long op rd=5, next cycle read rs2=5 → `hazard_stall`=1. Then `ld_valid`, rd=5, data 0x55 accepted → stall drops that cycle, `rs2_data`=0x55, and `busy[5]`=0 afterwards.
- `wb_we`=1 (rd=2) and `ld_valid`=1 (rd=7) in the same cycle → `ld_ready`=0 and only r2 is written. Next cycle `wb_we`=0 → the load is accepted and r7 is written.
- Issue long rd=6 with `flush`=1 → `busy[6]` stays 0. Issue long rd=6 without flush while the returning load for rd=6 is accepted the same cycle → `busy[6]`=1. A second issue of long rd=6 → `hazard_stall`=1.
- Set `busy[4]`, then assert reset asynchronously mid-cycle → `busy`=0, `hazard_stall`=0 and all registers 0 without waiting for a clock edge.

Source files
------------

// File: rtl/qtpa_pkg.sv
// Shared scalar-pipe parameters and types for the writeback-side register file.
package qtpa_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register for in-flight long-latency results,
// plus RAW/WAW hazard evaluation that drives the upstream stall.
module reg_scoreboard
  import qtpa_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid_i,
  input  logic                iss_long_i,
  input  reg_addr_t           iss_rd_addr_i,
  input  logic                flush_i,
  input  logic                ld_acc_i,
  input  reg_addr_t           ld_rd_addr_i,
  input  reg_addr_t           rs1_addr_i,
  input  reg_addr_t           rs2_addr_i,
  output logic                hazard_stall_o,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                raw1;
  logic                raw2;
  logic                waw;
  logic                set_en;

  // A load retiring this cycle resolves a RAW on its own address without a stall.
  always_comb begin
    raw1           = busy_q[rs1_addr_i] & ~(ld_acc_i & (ld_rd_addr_i == rs1_addr_i));
    raw2           = busy_q[rs2_addr_i] & ~(ld_acc_i & (ld_rd_addr_i == rs2_addr_i));
    waw            = iss_valid_i & busy_q[iss_rd_addr_i];
    hazard_stall_o = raw1 | raw2 | waw;
    set_en         = iss_valid_i & iss_long_i & ~flush_i & ~hazard_stall_o &
                     (iss_rd_addr_i != '0);
  end

  // Clear first, then set, so a same-index collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (ld_acc_i) busy_d[ld_rd_addr_i] = 1'b0;
    if (set_en)   busy_d[iss_rd_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/scalar_regfile_wb.sv
// End of the scalar pipe: 16-entry register file with ALU/load write arbitration,
// write-through bypass on both read ports and the pending-write scoreboard.
module scalar_regfile_wb
  import qtpa_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [3:0]            wb_rd_addr,
  input  logic [DATA_WIDTH-1:0] wb_alu_result,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [3:0]            ld_rd_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  iss_valid,
  input  logic                  iss_long,
  input  logic [3:0]            iss_rd_addr,
  input  logic                  flush,
  input  logic [3:0]            rs1_addr,
  input  logic [3:0]            rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  hazard_stall
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  ld_acc;
  logic                  alu_wr;
  logic                  ld_wr;

  // The ALU port owns the write port whenever it writes; loads wait.
  assign ld_ready = rst & ~wb_we;
  assign ld_acc   = ld_valid & ld_ready;
  assign alu_wr   = wb_we & (wb_rd_addr != '0);
  assign ld_wr    = ld_acc & (ld_rd_addr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (alu_wr) begin
      regs_q[wb_rd_addr] <= wb_alu_result;
    end else if (ld_wr) begin
      regs_q[ld_rd_addr] <= ld_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input reg_addr_t             a,
    input logic [DATA_WIDTH-1:0] arr_val
  );
    if (a == '0)                           return '0;
    else if (wb_we && wb_rd_addr == a)     return wb_alu_result;
    else if (ld_acc && ld_rd_addr == a)    return ld_data;
    else                                   return arr_val;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr, regs_q[rs1_addr]);
    rs2_data = read_port(rs2_addr, regs_q[rs2_addr]);
  end

  reg_scoreboard u_sb (
    .clk            (clk),
    .rst            (rst),
    .iss_valid_i    (iss_valid),
    .iss_long_i     (iss_long),
    .iss_rd_addr_i  (iss_rd_addr),
    .flush_i        (flush),
    .ld_acc_i       (ld_acc),
    .ld_rd_addr_i   (ld_rd_addr),
    .rs1_addr_i     (rs1_addr),
    .rs2_addr_i     (rs2_addr),
    .hazard_stall_o (hazard_stall),
    .busy_o         (busy)
  );

endmodule
